dat_mem_bank: RTL and testbench

DAT_MEM_BANK -- requirements
Module: dat_mem_bank

---
 rtl/dat_mem_bank.sv | 123 ++++++++++++
 tb/tb_dat_mem_bank.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dat_mem_bank.sv
`default_nettype none
// ============================================================================
// Module      : dat_mem_bank
// Description : Single-port word memory with a one-cycle access pipeline,
//               read-before-write semantics, tag echo, and a sequential
//               clear engine that zeroes the array after reset or on demand.
// Revision    : 1.0 - initial release
// ============================================================================
module dat_mem_bank #(
  parameter int W     = 8,
  parameter int DEPTH = 256,
  parameter int TW    = 12,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req,
  input  logic          wr_en,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  dat_in,
  input  logic [TW-1:0] tag_in,
  input  logic          clr_start,
  output logic          ready,
  output logic [W-1:0]  dat_out,
  output logic          dat_vld,
  output logic [TW-1:0] tag_out,
  output logic          clr_busy
);

  // One extra bit so DEPTH itself is representable when DEPTH is a power of two.
  localparam logic [AW:0]   c_depth = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] c_last  = AW'(DEPTH - 1);

  typedef enum logic [0:0] {
    S_CLR  = 1'b0,
    S_IDLE = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_ptr;
  logic [AW-1:0] w_ptr_nxt;
  logic          w_accept;
  logic          w_addr_ok;
  logic [W-1:0]  w_rd_data;
  logic [W-1:0]  core [0:DEPTH-1];

  assign ready     = (r_state == S_IDLE);
  assign clr_busy  = (r_state == S_CLR);
  assign w_accept  = req && ready;
  assign w_addr_ok = ({1'b0, addr} < c_depth);

  // State and clear-pointer register; reset restarts the clear from word 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_CLR;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // Next state: walk the pointer through the array, leave CLR after the last word.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      S_CLR: begin
        if (r_ptr == c_last) begin
          w_state_nxt = S_IDLE;
          w_ptr_nxt   = '0;
        end else begin
          w_ptr_nxt   = r_ptr + AW'(1);
        end
      end
      S_IDLE: begin
        w_ptr_nxt = '0;
        if (clr_start) begin
          w_state_nxt = S_CLR;
        end
      end
      default: begin
        w_state_nxt = S_CLR;
        w_ptr_nxt   = '0;
      end
    endcase
  end

  // Read path: out-of-range addresses read as zero and never index the array.
  always_comb begin
    w_rd_data = '0;
    if (w_addr_ok) begin
      w_rd_data = core[addr];
    end
  end

  // Completion register: pulse valid one cycle after accept, otherwise hold data/tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dat_out <= '0;
      dat_vld <= 1'b0;
      tag_out <= '0;
    end else begin
      dat_vld <= w_accept;
      if (w_accept) begin
        dat_out <= w_rd_data;
        tag_out <= tag_in;
      end
    end
  end

  // Array write port: accepted in-range writes in IDLE, zero fill while clearing.
  always_ff @(posedge clk) begin
    if (w_accept && wr_en && w_addr_ok) begin
      core[addr] <= dat_in;
    end else if (r_state == S_CLR) begin
      core[r_ptr] <= '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dat_mem_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_dat_mem_bank
// Description : Self-checking bench for dat_mem_bank: a default-size instance
//               driven by directed and random traffic against an array model,
//               plus a small DEPTH=6/W=16 instance for out-of-range behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dat_mem_bank;

  localparam int M_DEPTH = 256;
  localparam int M_W     = 8;
  localparam int M_TW    = 12;
  localparam int M_AW    = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req = 1'b0;
  logic              wr_en = 1'b0;
  logic [M_AW-1:0]   addr = '0;
  logic [M_W-1:0]    dat_in = '0;
  logic [M_TW-1:0]   tag_in = '0;
  logic              clr_start = 1'b0;
  logic              ready;
  logic [M_W-1:0]    dat_out;
  logic              dat_vld;
  logic [M_TW-1:0]   tag_out;
  logic              clr_busy;

  // Small instance: DEPTH 6 means addresses 6 and 7 are out of range.
  logic              rst2_n = 1'b0;
  logic              req2 = 1'b0;
  logic              wr2 = 1'b0;
  logic [2:0]        addr2 = '0;
  logic [15:0]       din2 = '0;
  logic [11:0]       tin2 = '0;
  logic              rdy2;
  logic [15:0]       dout2;
  logic              vld2;
  logic [11:0]       tout2;
  logic              busy2;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int   m_mem [M_DEPTH];
  int   m_clr_left;
  logic m_vld;
  int   m_dat;
  int   m_tag;
  logic seen_rdy;

  always #5 clk = ~clk;

  dat_mem_bank #(.W(M_W), .DEPTH(M_DEPTH), .TW(M_TW)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .wr_en(wr_en), .addr(addr),
    .dat_in(dat_in), .tag_in(tag_in), .clr_start(clr_start), .ready(ready),
    .dat_out(dat_out), .dat_vld(dat_vld), .tag_out(tag_out), .clr_busy(clr_busy)
  );

  dat_mem_bank #(.W(16), .DEPTH(6), .TW(12)) u_dut6 (
    .clk(clk), .rst_n(rst2_n), .req(req2), .wr_en(wr2), .addr(addr2),
    .dat_in(din2), .tag_in(tin2), .clr_start(1'b0), .ready(rdy2),
    .dat_out(dout2), .dat_vld(vld2), .tag_out(tout2), .clr_busy(busy2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_clr_left = M_DEPTH;
    foreach (m_mem[i]) m_mem[i] = 0;
    m_vld = 1'b0;
    m_dat = 0;
    m_tag = 0;
  endtask

  // One clock cycle on the main instance: drive, predict, then check outputs.
  task automatic cyc(input logic rq, input logic wr, input int a, input int d,
                     input int t, input logic cs);
    logic m_rdy;
    @(negedge clk);
    req       = rq;
    wr_en     = wr;
    addr      = M_AW'(a);
    dat_in    = M_W'(d);
    tag_in    = M_TW'(t);
    clr_start = cs;
    m_rdy     = (m_clr_left == 0);
    chk("ready", ready, m_rdy);
    chk("clr_busy", clr_busy, !m_rdy);
    seen_rdy  = ready;
    if (rq && m_rdy) begin
      m_vld = 1'b1;
      m_tag = t;
      m_dat = (a < M_DEPTH) ? m_mem[a] : 0;
      if (wr && a < M_DEPTH) m_mem[a] = d;
    end else begin
      m_vld = 1'b0;
    end
    // Nothing can observe the array during a clear, so zero it all at the start.
    if (m_clr_left > 0) m_clr_left--;
    else if (cs) begin
      m_clr_left = M_DEPTH;
      foreach (m_mem[i]) m_mem[i] = 0;
    end
    @(posedge clk);
    #1;
    chk("dat_vld", dat_vld, m_vld);
    chk("dat_out", dat_out, m_dat);
    chk("tag_out", tag_out, m_tag);
  endtask

  // Reset pulse spanning one rising edge, with a request pending to be dropped.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 1'b1;
    wr_en = 1'b1;
    #1;
    model_reset();
    chk("rst_ready", ready, 1'b0);
    chk("rst_busy", clr_busy, 1'b1);
    chk("rst_vld", dat_vld, 1'b0);
    chk("rst_dat", dat_out, 0);
    chk("rst_tag", tag_out, 0);
    @(posedge clk);
    #1;
    chk("rst_vld_edge", dat_vld, 1'b0);
    req   = 1'b0;
    wr_en = 1'b0;
    rst_n = 1'b1;
  endtask

  // Run cycles (with random requests that must be ignored) until ready rises.
  task automatic wait_ready(input string tag, input int exp_len);
    int cnt = 0;
    for (int i = 0; i < 2000; i++) begin
      cyc($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 255),
          $urandom_range(0, 255), $urandom_range(0, 4095), 1'b0);
      if (seen_rdy) break;
      cnt++;
    end
    chk(tag, cnt, exp_len);
  endtask

  task automatic cyc2(input logic rq, input logic wr, input int a, input int d, input int t);
    @(negedge clk);
    req2  = rq;
    wr2   = wr;
    addr2 = 3'(a);
    din2  = 16'(d);
    tin2  = 12'(t);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int last_a = 0;
    int a;
    int cnt;
    model_reset();
    seen_rdy = 1'b0;

    // Reset, default clear length, every address reads zero
    do_reset();
    wait_ready("clr_len_reset", M_DEPTH);
    for (int i = 0; i < M_DEPTH; i++) cyc(1'b1, 1'b0, i, 0, i, 1'b0);

    // Write then read same address back to back
    cyc(1'b1, 1'b1, 3, 8'hA5, 12'h001, 1'b0);
    chk("rbw_old", dat_out, 0);
    chk("rbw_tag", tag_out, 12'h001);
    cyc(1'b1, 1'b0, 3, 0, 12'h002, 1'b0);
    chk("rd_new", dat_out, 8'hA5);
    chk("rd_tag", tag_out, 12'h002);
    chk("rd_vld2", dat_vld, 1'b1);
    cyc(1'b0, 1'b0, 0, 0, 0, 1'b0);
    chk("vld_drop", dat_vld, 1'b0);

    // Fill 0..3, then clear coinciding with a write to 5
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, i, i + 1, 16 + i, 1'b0);
    cyc(1'b1, 1'b1, 5, 9, 12'h0AB, 1'b1);
    wait_ready("clr_len_start", M_DEPTH);
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, i, 0, 32 + i, 1'b0);

    // Random traffic with occasional clears
    for (int n = 0; n < 4000; n++) begin
      a = ($urandom_range(0, 3) == 0) ? last_a :
          ($urandom_range(0, 1) == 0) ? $urandom_range(0, 7) : $urandom_range(0, 255);
      last_a = a;
      cyc($urandom_range(0, 9) < 7, $urandom_range(0, 1), a, $urandom_range(0, 255),
          $urandom_range(0, 4095), $urandom_range(0, 499) == 0);
    end

    // Reset in the middle of a clear
    do_reset();
    for (int i = 0; i < 100; i++)
      cyc($urandom_range(0, 1), 1'b1, $urandom_range(0, 255), 8'h77, i, 1'b0);
    do_reset();
    wait_ready("clr_len_midrst", M_DEPTH);
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, $urandom_range(0, 255), 0, i, 1'b0);

    // Small instance: 6-cycle clear and out-of-range addresses
    @(posedge clk);
    #1;
    rst2_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rdy2) break;
      cnt++;
    end
    chk("clr6_len", cnt, 6);
    cyc2(1'b1, 1'b1, 7, 16'hBEEF, 5);
    chk("oor_wr_vld", vld2, 1'b1);
    chk("oor_wr_dat", dout2, 0);
    chk("oor_wr_tag", tout2, 5);
    cyc2(1'b1, 1'b0, 7, 0, 6);
    chk("oor_rd_vld", vld2, 1'b1);
    chk("oor_rd_dat", dout2, 0);
    chk("oor_rd_tag", tout2, 6);
    cyc2(1'b1, 1'b0, 1, 0, 9);
    chk("oor_alias", dout2, 0);
    cyc2(1'b1, 1'b1, 5, 16'h1234, 7);
    chk("top_wr_old", dout2, 0);
    cyc2(1'b1, 1'b0, 5, 0, 8);
    chk("top_rd", dout2, 16'h1234);
    cyc2(1'b0, 1'b0, 0, 0, 0);
    chk("s_vld_drop", vld2, 1'b0);
    chk("s_dat_hold", dout2, 16'h1234);
    chk("s_tag_hold", tout2, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
